// File: rtl/data_mem_responder.sv
// Word-wide load/store responder for the Memory-stage data port.
// Models a wait-state SRAM, returns a one-cycle response strobe and raises a stall while busy.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_stall_mem
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          r_state, w_state_d;
  logic [3:0]      r_cnt, w_cnt_d;
  logic            r_write;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_oob;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_oob;
  logic            w_eff_write;
  logic [AW-1:0]   w_eff_idx;
  logic [31:0]     w_eff_wdata;
  logic            w_eff_oob;
  logic            w_unused;

  assign w_unused = ^i_req_addr[1:0];

  assign w_accept = (r_state == StIdle) && i_req_valid;
  assign w_oob    = (i_req_addr[31:2] >= 30'(DEPTH_WORDS));

  // With zero wait states the access happens on the accepting edge, before the latches load.
  assign w_eff_write = (r_state == StIdle) ? i_req_write            : r_write;
  assign w_eff_idx   = (r_state == StIdle) ? i_req_addr[AW+1:2]     : r_idx;
  assign w_eff_wdata = (r_state == StIdle) ? i_req_wdata            : r_wdata;
  assign w_eff_oob   = (r_state == StIdle) ? w_oob                  : r_oob;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            w_state_d    = StResp;
            w_enter_resp = 1'b1;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_d    = StResp;
          w_enter_resp = 1'b1;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_oob   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_write <= i_req_write;
        r_idx   <= i_req_addr[AW+1:2];
        r_wdata <= i_req_wdata;
        r_oob   <= w_oob;
      end
      if (w_enter_resp && !w_eff_write) begin
        r_rdata <= w_eff_oob ? 32'h0 : r_mem[w_eff_idx];
      end
    end
  end

  // Array has no reset; contents survive it, and a reset edge cancels any pending store.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_enter_resp && w_eff_write && !w_eff_oob) begin
      r_mem[w_eff_idx] <= w_eff_wdata;
    end
  end

  assign o_req_ready  = (r_state == StIdle);
  assign o_resp_valid = (r_state == StResp);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = (r_state == StResp) && r_oob;
  assign o_stall_mem  = i_req_valid && !o_resp_valid;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipeline's Memory-stage data port. It accepts one word-wide load or store request from the datapath and models a parameterised wait-state SRAM. It returns read data with a one-cycle response strobe and drives a stall request to the hazard unit while an access is outstanding. Byte-lane merging and load extension remain in the datapath; this block performs whole-word accesses only.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two, 4..65536.
- WAIT_CYCLES, 2: wait states between acceptance and response; 0..15.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- req_valid  in  1  request present; the requester holds all req_* stable until resp_valid.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored; word index = req_addr[31:2].
- req_wdata  in  32  store data, full word (already merged upstream).
- req_ready  out  1  1 in IDLE only; a request is accepted when req_valid && req_ready at a clock edge.
- resp_valid  out  1  one-cycle strobe; access complete.
- resp_rdata  out  32  load data; holds its value until the next load response.
- resp_err  out  1  valid with resp_valid; address out of range.
- stall_mem  out  1  combinational: req_valid && !resp_valid; OR'd into the stallF, stallD and flush logic.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE transitions:
  - On acceptance, latch write, word index and wdata.
  - Load cnt with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: decrement cnt each cycle. When cnt==1, the next state is RESP.
- Entry into RESP (the edge that sets resp_valid):
  - Perform the access.
  - Store: array[idx] <= wdata; resp_rdata unchanged.
  - Load: resp_rdata <= array[idx].
- RESP: resp_valid=1 for exactly one cycle, then always go to IDLE. No acceptance in RESP, so a held request is never double-issued.
- Range check: idx >= DEPTH_WORDS sets resp_err=1. Stores are dropped, loads return 32'h0. Upper address bits are never silently aliased.
- The array is not initialised by reset. Contents survive reset.
- req_valid deasserted in IDLE: the block stays in IDLE and stall_mem=0.
- Changing req_* after acceptance has no effect; the latched values are used.

## Timing
- Reset (reset=0 at an edge): state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1. stall_mem then follows req_valid.
- Reset mid-transaction: the access is abandoned. A pending store is not written. No resp_valid is issued.
- Latency: request accepted at edge T gives resp_valid high in cycle T+1+WAIT_CYCLES.
- Store visibility: write data is visible to a load accepted at any later edge.
- Next acceptance: at the earliest, the edge ending cycle T+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+2 cycles.
- stall_mem:
  - High from the cycle req_valid rises through the cycle before resp_valid.
  - Low in the resp_valid cycle, so the pipeline advances on that edge.
- WAIT_CYCLES=0: accept at T, RESP in T+1, IDLE in T+2.
- resp_err is only meaningful while resp_valid=1. It is driven 0 otherwise.

## Test plan
- Reset, then idle with req_valid=0 for 10 cycles: req_ready=1, resp_valid=0, stall_mem=0, resp_rdata=0 throughout.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x40: resp_valid 3 cycles after acceptance; stall_mem high for exactly 3 cycles.
  - Load 0x43: resp_rdata=0xDEADBEEF, resp_err=0.
- WAIT_CYCLES=0 back-to-back: loads to 0x0/0x4/0x8 held until resp_valid. Each resp_valid arrives 1 cycle after acceptance. Accepts are spaced 2 cycles apart. Every address is accepted exactly once.
- Out of range, DEPTH_WORDS=256:
  - Store 0x12345678 to 0x400: resp_err=1 with resp_valid.
  - A subsequent load of 0x400 returns 0 with resp_err=1.
  - A load of 0x0 is unchanged.
- Reset mid-access: store 0xCAFEF00D to 0x10, then drive reset=0 in the first WAIT cycle. No resp_valid follows. A later load of 0x10 returns its prior contents. Post-reset outputs match the reset values.
- Request changed mid-WAIT: alter req_addr and req_wdata after acceptance. The response reflects the originally latched address and data.
